// File: rtl/lock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// lock_mode_ctrl
//
// Mode sequencer for the 3-digit switch password lock. It debounces the four
// push-buttons and turns them into the 5-bit mode code `big_current_state`,
// which drives the per-digit verification sequencer. It also tracks whether a
// password has been stored. The sequencer's LED feedback ends each verify
// attempt, and a third failure forces a timed lockout.
//
// Mode codes: 0 IDLE, 1 SET, 2 CONFIRM, 3 VPREP, 4 VERIFY, 5 LOCKOUT.
//
// Optional feature macro: IDLE_TIMEOUT_EN
//   When it is defined, SET and VPREP fall back to IDLE after TIMEOUT_CYCLES
//   cycles with no accepted press. When it is undefined, those modes wait
//   indefinitely and no inactivity counter is built.
//
// Parameters:
//   DEB_CYCLES     : consecutive stable synchronized samples needed to accept a
//                    button level (2..255)
//   VERIFY_CYCLES  : cycles spent in VERIFY (>= 12)
//   LOCKOUT_CYCLES : cycles spent in LOCKOUT
//   TIMEOUT_CYCLES : inactivity limit for SET/VPREP (IDLE_TIMEOUT_EN only)
//
// Ports:
//   clk               : system clock
//   rst               : synchronous active-high reset
//   btn_set           : raw button, enter password-set mode
//   btn_ok            : raw button, confirm the entered password
//   btn_verify        : raw button, start a verify attempt
//   btn_go            : raw button, launch the compare
//   test              : when 1, a confirm does not store the password
//   pass_led          : pass indication from the verification sequencer
//   fail_led2         : third-failure indication from the verification sequencer
//   big_current_state : registered mode code
//   pwd_valid         : registered, a password has been confirmed
//   lockout           : registered, high while in LOCKOUT
// -----------------------------------------------------------------------------

// Per-button front end: a 2-FF synchronizer, a stability counter, and a
// one-cycle pulse on each accepted rising level.
module lock_btn_deb #(
  parameter int unsigned DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       sync_p0;
  logic       sync_p1;
  logic       level_p2;
  logic [7:0] stab_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      level_p2 <= 1'b0;
      stab_cnt <= 8'd0;
      press    <= 1'b0;
    end else begin
      // stage p0/p1: metastability synchronizer
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // stage p2: accepted level plus press pulse
      press   <= 1'b0;
      if (sync_p1 != level_p2) begin
        // A run of DEB_CYCLES differing samples flips the accepted level.
        // Any agreeing sample restarts the run.
        if (stab_cnt == DEB_LAST) begin
          level_p2 <= sync_p1;
          stab_cnt <= 8'd0;
          press    <= sync_p1;
        end else begin
          stab_cnt <= stab_cnt + 8'd1;
        end
      end else begin
        stab_cnt <= 8'd0;
      end
    end
  end

endmodule

module lock_mode_ctrl #(
  parameter int unsigned DEB_CYCLES     = 20,
  parameter int unsigned VERIFY_CYCLES  = 12,
  parameter int unsigned LOCKOUT_CYCLES = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_ok,
  input  logic       btn_verify,
  input  logic       btn_go,
  input  logic       test,
  input  logic       pass_led,
  input  logic       fail_led2,
  output logic [4:0] big_current_state,
  output logic       pwd_valid,
  output logic       lockout
);

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_SET     = 5'd1,
    ST_CONFIRM = 5'd2,
    ST_VPREP   = 5'd3,
    ST_VERIFY  = 5'd4,
    ST_LOCKOUT = 5'd5
  } state_t;

  localparam logic [31:0] VERIFY_LAST  = 32'(VERIFY_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYCLES - 1);

  // Saturating increment: timing counters stick at all-ones and never wrap.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t      state;
  logic [31:0] phase_cnt;
  logic        press_set;
  logic        press_ok;
  logic        press_verify;
  logic        press_go;

  // The mode code is the state register itself, so it is registered.
  assign big_current_state = state;

  // The pass LED does not steer the FSM. A non-failing attempt always ends
  // in IDLE, and the sequencer's own LEDs already show the pass.
  logic pass_unused;
  assign pass_unused = pass_led;

  lock_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_set),
    .press (press_set)
  );

  lock_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_ok),
    .press (press_ok)
  );

  lock_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_verify (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_verify),
    .press (press_verify)
  );

  lock_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_go (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_go),
    .press (press_go)
  );

`ifdef IDLE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  logic [31:0] idle_cnt;
  logic        any_press;
  logic        idle_expired;

  // SET and VPREP are only ever entered on a press, so clearing on every
  // press also clears the counter on entry to those states.
  assign any_press    = press_set | press_ok | press_verify | press_go;
  assign idle_expired = !any_press && (idle_cnt >= TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 32'd0;
    end else begin
      idle_cnt <= any_press ? 32'd0 : sat_inc(idle_cnt);
    end
  end
`else
  logic        idle_expired;
  logic [31:0] tmo_unused;

  assign idle_expired = 1'b0;
  assign tmo_unused   = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pwd_valid <= 1'b0;
      lockout   <= 1'b0;
      phase_cnt <= 32'd0;
    end else begin
      phase_cnt <= sat_inc(phase_cnt);
      // When several pulses land together, only the highest-priority legal one
      // acts. The order is set > ok > verify > go.
      case (state)
        ST_IDLE: begin
          if (press_set) begin
            state <= ST_SET;
          end else if (press_verify && pwd_valid) begin
            state <= ST_VPREP;
          end
        end

        ST_SET: begin
          if (press_set) begin
            state <= ST_SET;
          end else if (press_ok) begin
            state <= ST_CONFIRM;
          end else if (idle_expired) begin
            state <= ST_IDLE;
          end
        end

        ST_CONFIRM: begin
          state <= ST_IDLE;
          if (!test) begin
            pwd_valid <= 1'b1;
          end
        end

        ST_VPREP: begin
          if (press_set) begin
            state <= ST_SET;
          end else if (press_go) begin
            state     <= ST_VERIFY;
            phase_cnt <= 32'd0;
          end else if (idle_expired) begin
            state <= ST_IDLE;
          end
        end

        ST_VERIFY: begin
          // The window covers the downstream compare and its LED update.
          // The LEDs are sampled at its end.
          if (phase_cnt >= VERIFY_LAST) begin
            phase_cnt <= 32'd0;
            if (fail_led2) begin
              state   <= ST_LOCKOUT;
              lockout <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_LOCKOUT: begin
          // Forgetting the password forces a new SET. That SET also clears
          // the downstream LEDs.
          if (phase_cnt >= LOCKOUT_LAST) begin
            state     <= ST_IDLE;
            lockout   <= 1'b0;
            pwd_valid <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          lockout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lock_mode_ctrl
//
// Scoreboard bench for lock_mode_ctrl.
//
// A transition-table model of the lock updates itself for each button action
// and queues the mode changes it expects. Each entry holds the mode, its
// dwell time (0 means "don't care"), pwd_valid and lockout. A separate
// monitor watches big_current_state on the falling edge. On every change it
// pops one entry and compares it, then checks the dwell time of the mode it
// has just left.
// -----------------------------------------------------------------------------
module tb_lock_mode_ctrl;

  localparam int DEB = 4;
  localparam int VC  = 12;
  localparam int LC  = 16;
  localparam int TC  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_set = 1'b0;
  logic       btn_ok = 1'b0;
  logic       btn_verify = 1'b0;
  logic       btn_go = 1'b0;
  logic       test = 1'b0;
  logic       pass_led = 1'b0;
  logic       fail_led2 = 1'b0;
  logic [4:0] big_current_state;
  logic       pwd_valid;
  logic       lockout;

  always #5 clk = ~clk;

  lock_mode_ctrl #(
    .DEB_CYCLES    (DEB),
    .VERIFY_CYCLES (VC),
    .LOCKOUT_CYCLES(LC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_set          (btn_set),
    .btn_ok           (btn_ok),
    .btn_verify       (btn_verify),
    .btn_go           (btn_go),
    .test             (test),
    .pass_led         (pass_led),
    .fail_led2        (fail_led2),
    .big_current_state(big_current_state),
    .pwd_valid        (pwd_valid),
    .lockout          (lockout)
  );

  typedef struct {
    int st;
    int dur;
    bit pv;
    bit lk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 idle, 1 set, 3 verify-prepare (other modes are transient).
  int   mdl_mode = 0;
  bit   mdl_pv   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_mode(input int st, input int dur, input bit pv, input bit lk);
    exp_t e;
    e.st  = st;
    e.dur = dur;
    e.pv  = pv;
    e.lk  = lk;
    sb.push_back(e);
  endtask

  // Button b: 0 set, 1 ok, 2 verify, 3 go. The model uses the test and
  // fail_led2 values that the stimulus holds stable across the action.
  task automatic model_step(input int b);
    case (mdl_mode)
      0: begin
        if (b == 0) begin
          expect_mode(1, 0, mdl_pv, 1'b0);
          mdl_mode = 1;
        end else if (b == 2 && mdl_pv) begin
          expect_mode(3, 0, mdl_pv, 1'b0);
          mdl_mode = 3;
        end
      end
      1: begin
        if (b == 1) begin
          expect_mode(2, 1, mdl_pv, 1'b0);
          if (!test) mdl_pv = 1'b1;
          expect_mode(0, 0, mdl_pv, 1'b0);
          mdl_mode = 0;
        end
      end
      3: begin
        if (b == 0) begin
          expect_mode(1, 0, mdl_pv, 1'b0);
          mdl_mode = 1;
        end else if (b == 3) begin
          expect_mode(4, VC, mdl_pv, 1'b0);
          if (fail_led2) begin
            expect_mode(5, LC, mdl_pv, 1'b1);
            mdl_pv = 1'b0;
          end
          expect_mode(0, 0, mdl_pv, 1'b0);
          mdl_mode = 0;
        end
      end
      default: mdl_mode = 0;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_set = v;
      1: btn_ok = v;
      2: btn_verify = v;
      default: btn_go = v;
    endcase
  endtask

  task automatic press_raw(input int b);
    set_btn(b, 1'b1);
    tick(2 * DEB);
    set_btn(b, 1'b0);
    tick(2 * DEB);
  endtask

  task automatic press(input int b);
    model_step(b);
    press_raw(b);
  endtask

  task automatic wait_state(input int st, input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (big_current_state == 5'(st)) found = 1'b1;
    end
    check($sformatf("reach_state%0d", st), {31'd0, found}, 32'd1);
  endtask

  // Monitor: compares each observed mode change with the next queued entry.
  bit         mon_en   = 1'b0;
  logic [4:0] mon_prev = 5'd0;
  int         mon_run  = 0;
  bit         mon_have = 1'b0;
  exp_t       mon_cur;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (big_current_state !== mon_prev) begin
          if (mon_have && mon_cur.dur != 0)
            check($sformatf("dwell_state%0d", mon_cur.st), mon_run, mon_cur.dur);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            mon_have = 1'b0;
            $display("FAIL unexpected_change: got state %0d, expected to stay %0d (t=%0t)",
                     big_current_state, mon_prev, $time);
          end else begin
            mon_cur  = sb.pop_front();
            mon_have = 1'b1;
            check("state", {27'd0, big_current_state}, mon_cur.st);
            check($sformatf("pwd_valid_at_state%0d", mon_cur.st), {31'd0, pwd_valid}, {31'd0, mon_cur.pv});
            check($sformatf("lockout_at_state%0d", mon_cur.st), {31'd0, lockout}, {31'd0, mon_cur.lk});
          end
          mon_prev = big_current_state;
          mon_run  = 1;
        end else begin
          mon_run++;
        end
      end
    end
  end

  initial begin : stim
    int b;
    bit is_go;

    // Reset
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);
    check("reset_state", {27'd0, big_current_state}, 32'd0);
    check("reset_pwd_valid", {31'd0, pwd_valid}, 32'd0);
    check("reset_lockout", {31'd0, lockout}, 32'd0);
    mon_en = 1'b1;

    // Verify with no stored password is ignored
    press(2);

    // Bounce, then a clean hold on set
    model_step(0);
    for (int i = 0; i < 10; i++) begin
      btn_set = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        tick(1);
        check("bounce_idle", {27'd0, big_current_state}, 32'd0);
      end
    end
    btn_set = 1'b1;
    wait_state(1, 12);
    tick(10);
    btn_set = 1'b0;
    tick(2 * DEB);

    // Confirm with test=1: the password is not stored
    test = 1'b1;
    press(1);
    test = 1'b0;
    check("test_confirm_pwd_valid", {31'd0, pwd_valid}, 32'd0);
    press(2);

    // Confirm with test=0: the password is stored
    press(0);
    press(1);
    check("confirm_pwd_valid", {31'd0, pwd_valid}, 32'd1);

    // Verify attempt that passes
    pass_led  = 1'b1;
    fail_led2 = 1'b0;
    press(2);
    press(3);
    tick(40);
    pass_led = 1'b0;

    // Verify attempt that fails for the third time, leading to lockout
    fail_led2 = 1'b1;
    press(2);
    press(3);
    wait_state(5, 20);
    fail_led2 = 1'b0;
    press_raw(0);
    tick(20);
    check("post_lockout_pwd_valid", {31'd0, pwd_valid}, 32'd0);
    check("post_lockout_lockout", {31'd0, lockout}, 32'd0);

    // Same-cycle set and verify in IDLE with a stored password: set wins
    press(0);
    press(1);
    model_step(0);
    btn_set    = 1'b1;
    btn_verify = 1'b1;
    tick(2 * DEB);
    btn_set    = 1'b0;
    btn_verify = 1'b0;
    tick(2 * DEB);
    check("priority_state", {27'd0, big_current_state}, 32'd1);

    // Reset in the middle of VERIFY
    press(1);
    press(2);
    expect_mode(4, 0, mdl_pv, 1'b0);
    expect_mode(0, 0, 1'b0, 1'b0);
    mdl_mode = 0;
    mdl_pv   = 1'b0;
    btn_go = 1'b1;
    wait_state(4, 20);
    btn_go = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_abort_state", {27'd0, big_current_state}, 32'd0);
    check("rst_abort_pwd_valid", {31'd0, pwd_valid}, 32'd0);
    tick(4);

    // Inactivity in SET
    press(0);
`ifdef IDLE_TIMEOUT_EN
    expect_mode(0, 0, mdl_pv, 1'b0);
    mdl_mode = 0;
    tick(3 * TC);
    check("timeout_state", {27'd0, big_current_state}, 32'd0);
`else
    tick(200);
    check("no_timeout_state", {27'd0, big_current_state}, 32'd1);
    test = 1'b1;
    press(1);
    test = 1'b0;
`endif

    // Randomized button actions checked against the model
    for (int n = 0; n < 40; n++) begin
      b         = int'($urandom_range(0, 3));
      test      = $urandom_range(0, 1) == 1;
      fail_led2 = $urandom_range(0, 1) == 1;
      pass_led  = $urandom_range(0, 1) == 1;
      is_go     = (mdl_mode == 3 && b == 3);
      press(b);
      if (is_go) tick(40);
    end
    fail_led2 = 1'b0;
    tick(20);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_mode_ctrl.md
Name: lock_mode_ctrl

Overview:
- Top-level mode sequencer for the 3-digit switch password lock.
- Turns debounced push-buttons into the 5-bit `big_current_state` consumed by the per-digit verification sequencer.
- Tracks whether a password has been stored.
- Uses that sequencer's LED feedback to end a verify attempt, and enforces a lockout after the third failed attempt.

Parameters:
- DEB_CYCLES, 20: consecutive stable synchronized samples needed to accept a button level; range 2..255.
- VERIFY_CYCLES, 12: cycles spent in VERIFY; must be ≥ 12 so the downstream 10-cycle compare and its LED update complete.
- LOCKOUT_CYCLES, 100: cycles spent in LOCKOUT; 32-bit counter.
- TIMEOUT_CYCLES, 1000: inactivity limit; only used when IDLE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn_set  in  1  raw button: enter password-set mode
- btn_ok  in  1  raw button: confirm the entered password
- btn_verify  in  1  raw button: start a verify attempt
- btn_go  in  1  raw button: launch the compare
- test  in  1  test switch; when 1, the confirm does not store a password
- pass_led  in  1  pass indication from the verification sequencer (its gled1)
- fail_led2  in  1  third-failure indication from the verification sequencer (its rled2)
- big_current_state  out  5  mode code; registered
- pwd_valid  out  1  a password has been confirmed; registered
- lockout  out  1  high while in LOCKOUT; registered

Behaviour:
- Reset: rst is synchronous and active-high, sampled on posedge clk. Reset gives:
  - state IDLE, big_current_state=0, pwd_valid=0, lockout=0;
  - all counters 0;
  - debounced button levels 0.
- Button front end, identical per button:
  - 2-FF synchronizer.
  - Stability counter: the accepted level changes only after DEB_CYCLES consecutive synchronized samples that differ from it.
  - A 1-cycle press pulse fires on the accepted 0→1 change only; holding a button produces no repeats.
- Press pulses reach the FSM one cycle after acceptance.
- Same-cycle pulses are prioritised set > ok > verify > go. Only the highest-priority legal pulse acts; the rest are dropped.
- State encoding is `big_current_state`:

  | Code | State   |
  |------|---------|
  | 0    | IDLE    |
  | 1    | SET     |
  | 2    | CONFIRM |
  | 3    | VPREP   |
  | 4    | VERIFY  |
  | 5    | LOCKOUT |

- Transitions:
  - IDLE: set→SET. verify→VPREP only if pwd_valid=1; otherwise ignored.
  - SET: ok→CONFIRM. set→SET (no-op).
  - CONFIRM: lasts exactly 1 cycle, then →IDLE. In that cycle, if test=0, pwd_valid←1 on the next edge; if test=1, pwd_valid is unchanged.
  - VPREP: go→VERIFY. set→SET.
  - VERIFY: a cycle counter runs from 0. After VERIFY_CYCLES cycles in VERIFY, the FSM samples fail_led2 and pass_led:
    - fail_led2=1 → LOCKOUT;
    - otherwise → IDLE, whatever pass_led is.
    - Buttons are ignored in VERIFY.
  - LOCKOUT: lockout=1. All buttons are ignored. After LOCKOUT_CYCLES cycles → IDLE and pwd_valid←0; a new SET is required, which clears the downstream LEDs.
- The VERIFY and LOCKOUT counters clear on every state entry. They saturate and never wrap.
- big_current_state and lockout update on the same edge as the state register. There is no combinational path from any input to any output.
- Reset asserted mid-VERIFY or mid-LOCKOUT aborts immediately to IDLE, with pwd_valid=0.

Optional Feature:
- Macro: IDLE_TIMEOUT_EN.
- Defined: in SET or VPREP, an inactivity counter clears on every accepted press pulse and on state entry. When it reaches TIMEOUT_CYCLES, the FSM → IDLE on the next edge and pwd_valid is unchanged.
- Undefined: SET and VPREP wait indefinitely, and the counter logic is absent.

Test Plan:
Bench parameters: DEB_CYCLES=4, VERIFY_CYCLES=12, LOCKOUT_CYCLES=16, TIMEOUT_CYCLES=40.
1. Bounce: toggle btn_set every 2 cycles for 20 cycles, then hold it high for 10 cycles → state stays 0 during the toggling, reaches 1 exactly once after the hold, and produces no second transition while the button stays held.
2. Set path, test=0: set, then ok → big_current_state goes 0→1→2 (2 for exactly 1 cycle)→0; pwd_valid=1. Repeat with test=1 and pwd_valid initially 0 → pwd_valid stays 0.
3. Verify guard: btn_verify with pwd_valid=0 → state stays 0. With pwd_valid=1: verify, then go → 3, then 4 for exactly 12 cycles, then 0 with fail_led2=0.
4. Lockout: fail_led2=1 at the end of VERIFY → state 5 and lockout=1 for 16 cycles; a btn_set pressed during lockout is ignored; then state 0, lockout=0, pwd_valid=0.
5. Priority and reset: btn_set and btn_verify accepted in the same cycle in IDLE with pwd_valid=1 → state 1. rst pulsed at cycle 5 of VERIFY → next edge gives state 0, pwd_valid=0.
6. IDLE_TIMEOUT_EN defined: enter SET, no presses for 40 cycles → state 0, pwd_valid unchanged. Macro undefined: state stays 1 after 200 cycles.
